serial_to_parallel: RTL and testbench
=====================================

# serial_to_parallel

Receive-side counterpart of the team's parallel-to-serial converter. Samples one serial bit per enabled clock, assembles `WIDTH` bits into a word, and presents it on a held parallel output with a one-cycle `valid` strobe. Sits at the far end of a serial link driven by the transmitter, with `enable` qualifying each bit time. Supports continuous back-to-back words with no idle cycle between them.

## Interface
- `WIDTH`, default 8: word width in bits; legal range 2..32.
- `CNT_W`, default `$clog2(WIDTH)`: width of the bit counter; derived, not overridden.

- `clk`  input  1  rising-edge clock.
- `reset_n`  input  1  asynchronous active-low reset.
- `enable`  input  1  bit qualifier: `serial_in` is sampled on each rising edge where `enable`=1.
- `serial_in`  input  1  serial data bit.
- `clear`  input  1  synchronous word-realignment: discards the partial word.
- `parallel_out`  output  `WIDTH`  last completed word; held until the next word completes.
- `valid`  output  1  one-cycle pulse: `parallel_out` has just been updated.
- `busy`  output  1  partial word in progress (`bit_count` != 0).
- `bit_count`  output  `CNT_W`  number of bits captured in the current word.

One clock; reset is asynchronous and active-low.

## Operation
- Datapath: shift register `sreg[WIDTH-1:0]`, counter `bit_count`, output register `parallel_out`.
- Default order is MSB first: on a sampled bit, `sreg <= {sreg[WIDTH-2:0], serial_in}`. The first bit received lands in `parallel_out[WIDTH-1]`.
- States, implied by `bit_count`:
  - IDLE: `bit_count`=0.
  - SHIFT: `bit_count` in 1..`WIDTH-1`.
- Per rising edge, in priority order:
  1. `clear`=1: `bit_count`<=0, `sreg`<=0, `valid`<=0. `parallel_out` is held. `enable` is ignored this edge.
  2. `enable`=1 and `bit_count`<`WIDTH-1`: shift in the bit, `bit_count`++, `valid`<=0.
  3. `enable`=1 and `bit_count`=`WIDTH-1` (last bit):
     - `parallel_out` <= the shifted word including the current bit (computed combinationally, not taken from the stale `sreg`).
     - `valid`<=1, `bit_count`<=0, `sreg`<=0.
  4. `enable`=0: hold `sreg` and `bit_count`, `valid`<=0.
- Gaps in `enable` of any length are transparent; the partial word is retained.
- Streaming: if `enable` stays high after the last bit, the next edge captures bit 0 of the next word. There is no dead cycle.
- Counter arithmetic wraps explicitly from `WIDTH-1` to 0. `bit_count` never reaches `WIDTH`.

## Timing
- Reset values (asynchronous, while `reset_n`=0): `parallel_out`=0, `valid`=0, `busy`=0, `bit_count`=0, `sreg`=0.
- Reset mid-word: the partial word is lost. After release, the first enabled edge is bit 0.
- Latency: the word is visible on `parallel_out`, and `valid` is high, in the cycle immediately after the edge that samples the last bit.
- `valid` is high for exactly one cycle per completed word. For continuous `enable`, consecutive pulses are `WIDTH` cycles apart.
- `busy` is combinational from `bit_count` (`bit_count`!=0). It is high from the edge after bit 0 until the edge that samples the last bit.
- `clear` together with the last bit: `clear` wins. No `valid`, and `parallel_out` is unchanged.
- All outputs are registered except `busy`. There is no combinational path from inputs to outputs.

## Configuration
- Macro: `S2P_LSB_FIRST_EN`.
- Defined: LSB-first order, `sreg <= {serial_in, sreg[WIDTH-1:1]}`. The first bit received lands in `parallel_out[0]`. Pairs with a transmitter built LSB-first.
- Undefined (default): MSB-first, as described under Operation.
- Counter, `valid` and `clear` behaviour are identical in both builds.

## Test plan
- Reset: hold `reset_n`=0 with `enable`=1 and toggling `serial_in` -> all outputs 0 and no `valid`. Release -> `bit_count`=0.
- Single word, MSB first: `enable`=1 for 8 cycles, bits 1,0,1,1,0,1,1,0 -> `parallel_out`=8'hB6, `valid` high for exactly one cycle after the 8th edge, `busy` low in that cycle.
- Back-to-back: continuous `enable`, words 8'hB6 then 8'h5A -> two `valid` pulses 8 cycles apart. `parallel_out` holds 8'hB6 between them, then 8'h5A.
- Enable gaps: 8'hB6 sent with `enable` low for 3 cycles after bits 2 and 5 -> `bit_count` frozen during the gaps, result 8'hB6, one `valid`.
- Clear and async reset mid-word:
  - `clear` after 3 bits -> `bit_count`=0, no `valid`, `parallel_out` unchanged; the next full word 8'h5A is received correctly.
  - `reset_n` pulse after 5 bits -> outputs 0 immediately, without waiting for a clock edge.
- LSB-first build (`S2P_LSB_FIRST_EN` defined): bits 0,1,1,0,1,1,0,1 -> `parallel_out`=8'hB6 with one `valid` pulse.

Source files
------------

// File: rtl/serial_to_parallel.sv
// -----------------------------------------------------------------------------
// serial_to_parallel
//
// Receive-side serial-to-parallel converter. One serial bit is sampled on each
// rising edge where `enable` is high. WIDTH bits are assembled into a word,
// which is presented on a held parallel output together with a one-cycle
// `valid` strobe. Back-to-back words stream with no idle cycle between them.
// Gaps in `enable` of any length leave the partial word intact.
//
// Bit order:
//   default               : MSB first, so the first bit lands in parallel_out[WIDTH-1]
//   `S2P_LSB_FIRST_EN     : LSB first, so the first bit lands in parallel_out[0]
//
// Parameters:
//   WIDTH        word width in bits, 2..32
//   CNT_W        bit counter width, derived from WIDTH (do not override)
//
// Ports:
//   clk          rising-edge clock
//   reset_n      asynchronous active-low reset
//   enable       bit qualifier; serial_in is sampled when high
//   serial_in    serial data bit
//   clear        synchronous realignment; discards the partial word, wins
//                over enable
//   parallel_out last completed word, held until the next word completes
//   valid        one-cycle pulse: parallel_out has just been updated
//   busy         partial word in progress (bit_count != 0), combinational
//   bit_count    number of bits captured in the current word
// -----------------------------------------------------------------------------
module serial_to_parallel #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             serial_in,
    input  logic             clear,
    output logic [WIDTH-1:0] parallel_out,
    output logic             valid,
    output logic             busy,
    output logic [CNT_W-1:0] bit_count
);

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    logic [WIDTH-1:0] sreg_q,  sreg_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [WIDTH-1:0] pout_q,  pout_d;
    logic             valid_q, valid_d;

    // Shift register contents including the bit being sampled this edge. On
    // the last bit this is the completed word; sreg_q alone would still be
    // one bit short.
    logic [WIDTH-1:0] shifted;
    logic             last_bit;

`ifdef S2P_LSB_FIRST_EN
    assign shifted = {serial_in, sreg_q[WIDTH-1:1]};
`else
    assign shifted = {sreg_q[WIDTH-2:0], serial_in};
`endif

    assign last_bit = (cnt_q == LAST_BIT);

    // Next-state logic. The IDLE/SHIFT state is implied by the counter value,
    // so no separate state register is kept.
    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        sreg_d  = sreg_q;
        cnt_d   = cnt_q;
        pout_d  = pout_q;
        valid_d = 1'b0;

        if (clear) begin
            // Realignment discards the partial word; the last completed word
            // stays on the output.
            sreg_d = '0;
            cnt_d  = '0;
        end else if (enable) begin
            if (last_bit) begin
                pout_d  = shifted;
                valid_d = 1'b1;
                sreg_d  = '0;
                cnt_d   = '0;  // explicit wrap; the counter never reaches WIDTH
            end else begin
                sreg_d = shifted;
                cnt_d  = cnt_q + CNT_W'(1);
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sreg_q  <= '0;
            cnt_q   <= '0;
            pout_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            sreg_q  <= sreg_d;
            cnt_q   <= cnt_d;
            pout_q  <= pout_d;
            valid_q <= valid_d;
        end
    end

    assign parallel_out = pout_q;
    assign valid        = valid_q;
    assign bit_count    = cnt_q;
    assign busy         = (cnt_q != '0);

endmodule

// File: tb/tb_serial_to_parallel.sv
// -----------------------------------------------------------------------------
// tb_serial_to_parallel
//
// Directed self-checking bench for serial_to_parallel (WIDTH = 8). Words are
// sent in the bit order of the build (MSB first by default, LSB first with
// S2P_LSB_FIRST_EN), so word-level expectations are the same in both builds.
// test_bit_order sends a raw bit sequence whose expected word depends on the
// build. Inputs change on the falling edge; outputs are sampled 1 time unit
// after the rising edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_serial_to_parallel;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         enable = 1'b0;
    logic         serial_in = 1'b0;
    logic         clear = 1'b0;
    logic [W-1:0] parallel_out;
    logic         valid;
    logic         busy;
    logic [2:0]   bit_count;

    int n_cmp = 0;
    int n_err = 0;

    serial_to_parallel #(.WIDTH(W)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .enable       (enable),
        .serial_in    (serial_in),
        .clear        (clear),
        .parallel_out (parallel_out),
        .valid        (valid),
        .busy         (busy),
        .bit_count    (bit_count)
    );

    always #5 clk = ~clk;

    // Bit k (0 = first sent) of word w in the bit order of this build.
    function automatic logic bit_of(input logic [W-1:0] w, input int k);
`ifdef S2P_LSB_FIRST_EN
        return w[k];
`else
        return w[W-1-k];
`endif
    endfunction

    // Apply inputs for one clock and return just after the rising edge.
    task automatic drive(input logic en, input logic sin, input logic clr);
        @(negedge clk);
        enable    = en;
        serial_in = sin;
        clear     = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, i[0], 1'b0);
            n_cmp++;
            if ({parallel_out, valid, busy, bit_count} !== '0) begin
                n_err++;
                $display("FAIL reset_hold[%0d]: got pout=%h valid=%b busy=%b cnt=%0d, want all 0",
                         i, parallel_out, valid, busy, bit_count);
            end
        end
        @(negedge clk);
        enable  = 1'b0;
        reset_n = 1'b1;
        drive(1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (bit_count !== 3'd0 || valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_release: got cnt=%0d valid=%b, want cnt=0 valid=0", bit_count, valid);
        end
    endtask

    task automatic test_single_word();
        logic [W-1:0] w = 8'hB6;
        for (int k = 0; k < W; k++) begin
            drive(1'b1, bit_of(w, k), 1'b0);
            if (k < W-1) begin
                n_cmp++;
                if (bit_count !== 3'(k+1) || valid !== 1'b0 || busy !== 1'b1) begin
                    n_err++;
                    $display("FAIL single_progress[%0d]: got cnt=%0d valid=%b busy=%b, want cnt=%0d valid=0 busy=1",
                             k, bit_count, valid, busy, k+1);
                end
            end
        end
        n_cmp++;
        if (parallel_out !== 8'hB6 || valid !== 1'b1 || busy !== 1'b0 || bit_count !== 3'd0) begin
            n_err++;
            $display("FAIL single_done: got pout=%h valid=%b busy=%b cnt=%0d, want pout=b6 valid=1 busy=0 cnt=0",
                     parallel_out, valid, busy, bit_count);
        end
        drive(1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (valid !== 1'b0 || parallel_out !== 8'hB6) begin
            n_err++;
            $display("FAIL single_after: got valid=%b pout=%h, want valid=0 pout=b6", valid, parallel_out);
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] words [2] = '{8'hB6, 8'h5A};
        int pulses = 0;
        int first_at = -1;
        int second_at = -1;
        for (int k = 0; k < 2*W; k++) begin
            drive(1'b1, bit_of(words[k/W], k%W), 1'b0);
            if (valid === 1'b1) begin
                pulses++;
                if (first_at < 0) first_at = k; else second_at = k;
            end
            if (k < 2*W-1) begin
                n_cmp++;
                if (parallel_out !== 8'hB6) begin
                    n_err++;
                    $display("FAIL b2b_hold[%0d]: got pout=%h, want b6", k, parallel_out);
                end
            end
        end
        n_cmp++;
        if (parallel_out !== 8'h5A) begin
            n_err++;
            $display("FAIL b2b_second: got pout=%h, want 5a", parallel_out);
        end
        n_cmp++;
        if (pulses !== 2 || first_at !== W-1 || second_at !== 2*W-1) begin
            n_err++;
            $display("FAIL b2b_pulses: got %0d pulses at %0d,%0d, want 2 pulses at %0d,%0d",
                     pulses, first_at, second_at, W-1, 2*W-1);
        end
    endtask

    task automatic test_enable_gaps();
        logic [W-1:0] w = 8'hB6;
        int pulses = 0;
        for (int k = 0; k < W; k++) begin
            drive(1'b1, bit_of(w, k), 1'b0);
            if (valid === 1'b1) pulses++;
            if (k == 1 || k == 4) begin
                for (int g = 0; g < 3; g++) begin
                    drive(1'b0, ~bit_of(w, k), 1'b0);
                    n_cmp++;
                    if (bit_count !== 3'(k+1) || valid !== 1'b0) begin
                        n_err++;
                        $display("FAIL gap_freeze[%0d.%0d]: got cnt=%0d valid=%b, want cnt=%0d valid=0",
                                 k, g, bit_count, valid, k+1);
                    end
                end
            end
        end
        n_cmp++;
        if (parallel_out !== 8'hB6 || pulses !== 1) begin
            n_err++;
            $display("FAIL gap_result: got pout=%h pulses=%0d, want pout=b6 pulses=1", parallel_out, pulses);
        end
    endtask

    task automatic test_clear();
        logic [W-1:0] w = 8'h5A;
        for (int k = 0; k < 3; k++) drive(1'b1, bit_of(w, k), 1'b0);
        drive(1'b1, 1'b1, 1'b1);
        n_cmp++;
        if (bit_count !== 3'd0 || valid !== 1'b0 || parallel_out !== 8'hB6) begin
            n_err++;
            $display("FAIL clear_mid: got cnt=%0d valid=%b pout=%h, want cnt=0 valid=0 pout=b6",
                     bit_count, valid, parallel_out);
        end
        for (int k = 0; k < W; k++) drive(1'b1, bit_of(w, k), 1'b0);
        n_cmp++;
        if (parallel_out !== 8'h5A || valid !== 1'b1) begin
            n_err++;
            $display("FAIL clear_next_word: got pout=%h valid=%b, want pout=5a valid=1", parallel_out, valid);
        end
        // clear arriving with the last bit wins: no word, no strobe.
        for (int k = 0; k < W-1; k++) drive(1'b1, bit_of(8'hFF, k), 1'b0);
        drive(1'b1, 1'b1, 1'b1);
        n_cmp++;
        if (valid !== 1'b0 || parallel_out !== 8'h5A || bit_count !== 3'd0) begin
            n_err++;
            $display("FAIL clear_last_bit: got valid=%b pout=%h cnt=%0d, want valid=0 pout=5a cnt=0",
                     valid, parallel_out, bit_count);
        end
        drive(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_async_reset();
        logic [W-1:0] w = 8'h5A;
        for (int k = 0; k < 5; k++) drive(1'b1, bit_of(8'hC3, k), 1'b0);
        #2;
        reset_n = 1'b0;
        #1;
        n_cmp++;
        if ({parallel_out, valid, busy, bit_count} !== '0) begin
            n_err++;
            $display("FAIL async_reset: got pout=%h valid=%b busy=%b cnt=%0d, want all 0",
                     parallel_out, valid, busy, bit_count);
        end
        @(negedge clk);
        enable  = 1'b0;
        reset_n = 1'b1;
        for (int k = 0; k < W; k++) drive(1'b1, bit_of(w, k), 1'b0);
        n_cmp++;
        if (parallel_out !== 8'h5A || valid !== 1'b1) begin
            n_err++;
            $display("FAIL reset_realign: got pout=%h valid=%b, want pout=5a valid=1", parallel_out, valid);
        end
    endtask

    task automatic test_bit_order();
        logic [W-1:0] raw = 8'b0110_1101;  // raw[7] is sent first
        logic [W-1:0] exp_word;
`ifdef S2P_LSB_FIRST_EN
        exp_word = 8'hB6;
`else
        exp_word = 8'h6D;
`endif
        for (int k = 0; k < W; k++) drive(1'b1, raw[W-1-k], 1'b0);
        n_cmp++;
        if (parallel_out !== exp_word || valid !== 1'b1) begin
            n_err++;
            $display("FAIL bit_order: got pout=%h valid=%b, want pout=%h valid=1",
                     parallel_out, valid, exp_word);
        end
        drive(1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_back_to_back();
        test_enable_gaps();
        test_clear();
        test_async_reset();
        test_bit_order();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
